// File: rtl/letter_glyph_writer.sv
// rtl/letter_glyph_writer.sv - renders 8x16 glyphs and full clears into the 1-bit letter frame buffer
module letter_glyph_writer #(
    parameter int FB_W_LOG2 = 8,
    parameter int COL_W     = 5,
    parameter int ROW_W     = 4,
    parameter int ADDR_W    = 16
) (
    input  logic              clka,
    input  logic              reseta,
    input  logic              chr_valid,
    output logic              chr_ready,
    input  logic [6:0]        chr_code,
    input  logic [COL_W-1:0]  chr_col,
    input  logic [ROW_W-1:0]  chr_row,
    input  logic              clr_req,
    input  logic              clr_val,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_data,
    output logic              cea,
    output logic [ADDR_W-1:0] ada,
    output logic              din,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_CLEAR
    } state_t;

    state_t             state_q, state_n;
    logic [6:0]         code_q, code_n;
    logic [COL_W-1:0]   col_q, col_n;
    logic [ROW_W-1:0]   row_q, row_n;
    logic [3:0]         line_q, line_n;
    logic [2:0]         px_q, px_n;
    logic [7:0]         sh_q, sh_n;
    logic [10:0]        font_addr_n;
    logic               cea_n, din_n, busy_n, done_n;
    logic [ADDR_W-1:0]  ada_n;
    logic [ADDR_W-1:0]  line_base;

    // Pixel 0 of the current glyph line; pixels 1..7 only touch the low 3 bits.
    assign line_base = (ADDR_W'({row_q, line_q}) << FB_W_LOG2) | (ADDR_W'(col_q) << 3);

    assign chr_ready = (state_q == S_IDLE) & ~clr_req;

    always_comb begin
        state_n     = state_q;
        code_n      = code_q;
        col_n       = col_q;
        row_n       = row_q;
        line_n      = line_q;
        px_n        = px_q;
        sh_n        = sh_q;
        font_addr_n = font_addr;
        cea_n       = 1'b0;
        ada_n       = ada;
        din_n       = din;
        busy_n      = busy;
        done_n      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_n = S_CLEAR;
                    cea_n   = 1'b1;
                    ada_n   = '0;
                    din_n   = clr_val;
                    busy_n  = 1'b1;
                end else if (chr_valid) begin
                    state_n     = S_FETCH;
                    code_n      = chr_code;
                    col_n       = chr_col;
                    row_n       = chr_row;
                    line_n      = 4'd0;
                    font_addr_n = {chr_code, 4'd0};
                    busy_n      = 1'b1;
                end
            end
            S_FETCH: state_n = S_WAIT;
            S_WAIT: begin
                state_n = S_WRITE;
                px_n    = 3'd0;
                cea_n   = 1'b1;
                ada_n   = line_base;
                din_n   = font_data[7];
                sh_n    = {font_data[6:0], 1'b0};
            end
            S_WRITE: begin
                if (px_q != 3'd7) begin
                    px_n  = px_q + 3'd1;
                    cea_n = 1'b1;
                    ada_n = ada + ADDR_W'(1);
                    din_n = sh_q[7];
                    sh_n  = {sh_q[6:0], 1'b0};
                end else if (line_q != 4'd15) begin
                    state_n     = S_FETCH;
                    line_n      = line_q + 4'd1;
                    font_addr_n = {code_q, line_q + 4'd1};
                end else begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            S_CLEAR: begin
                if (&ada) begin
                    state_n = S_IDLE;
                    ada_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    cea_n = 1'b1;
                    ada_n = ada + ADDR_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge reseta) begin
        if (reseta) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            line_q    <= '0;
            px_q      <= '0;
            sh_q      <= '0;
            font_addr <= '0;
            cea       <= 1'b0;
            ada       <= '0;
            din       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            code_q    <= code_n;
            col_q     <= col_n;
            row_q     <= row_n;
            line_q    <= line_n;
            px_q      <= px_n;
            sh_q      <= sh_n;
            font_addr <= font_addr_n;
            cea       <= cea_n;
            ada       <= ada_n;
            din       <= din_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_letter_glyph_writer.sv
// tb/tb_letter_glyph_writer.sv - directed bench for letter_glyph_writer
module tb_letter_glyph_writer;

    logic        clk = 1'b0;
    logic        reseta;
    logic        chr_valid;
    logic        chr_ready;
    logic [6:0]  chr_code;
    logic [4:0]  chr_col;
    logic [3:0]  chr_row;
    logic        clr_req;
    logic        clr_val;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic        cea;
    logic [15:0] ada;
    logic        din;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]  code;
        logic [4:0]  col;
        logic [3:0]  row;
        logic [15:0] first_ada;
        logic [15:0] last_ada;
    } vec_t;

    vec_t tbl[4];

    letter_glyph_writer dut (
        .clka      (clk),
        .reseta    (reseta),
        .chr_valid (chr_valid),
        .chr_ready (chr_ready),
        .chr_code  (chr_code),
        .chr_col   (chr_col),
        .chr_row   (chr_row),
        .clr_req   (clr_req),
        .clr_val   (clr_val),
        .font_addr (font_addr),
        .font_data (font_data),
        .cea       (cea),
        .ada       (ada),
        .din       (din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [6:0] code, input logic [3:0] line);
        logic [7:0] h;
        if (code == 7'h41 && line == 4'd0) return 8'h18;
        h = {1'b0, code} * 8'd37 + {4'd0, line} * 8'd13;
        return h ^ 8'hA5;
    endfunction

    always @(posedge clk) font_data <= rom_byte(font_addr[10:4], font_addr[3:0]);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request one glyph, then check every output cycle E0+1..E0+161 against the line model.
    task automatic run_glyph(input vec_t v, input bit chain, input vec_t nv, input bit imm);
        int         wait_n;
        int         nwr;
        int         m;
        int         ln;
        int         p;
        logic [7:0] b;
        logic [15:0] exp_ada;
        logic [15:0] first_seen;
        logic [15:0] last_seen;
        chr_code  = v.code;
        chr_col   = v.col;
        chr_row   = v.row;
        chr_valid = 1'b1;
        #1;
        wait_n = 0;
        while (!chr_ready && wait_n < 70000) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        if (imm) chk("accept_latency", wait_n, 0);
        if (!chr_ready) begin
            chk("accept_timeout", 0, 1);
            chr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        nwr        = 0;
        first_seen = 16'hxxxx;
        last_seen  = 16'hxxxx;
        for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            if (k == 1) chr_valid = 1'b0;
            if (cea) begin
                if (nwr == 0) first_seen = ada;
                last_seen = ada;
                nwr++;
            end
            if (k < 161) begin
                chk("glyph_busy", busy, 1);
                chk("glyph_done_early", done, 0);
                if (k >= 3) begin
                    m  = k - 3;
                    ln = m / 10;
                    p  = m % 10;
                    chk("glyph_cea", cea, p < 8);
                    if (p < 8) begin
                        b       = rom_byte(v.code, ln[3:0]);
                        exp_ada = 16'(((v.row * 16 + ln) << 8) + v.col * 8 + p);
                        chk("glyph_ada", ada, exp_ada);
                        chk("glyph_din", din, b[7 - p]);
                    end
                end else begin
                    chk("glyph_cea_lead", cea, 0);
                end
            end else begin
                chk("glyph_done", done, 1);
                chk("glyph_busy_end", busy, 0);
                chk("glyph_cea_end", cea, 0);
                chk("glyph_ready_end", chr_ready, 1);
                chk("glyph_writes", nwr, 128);
                chk("glyph_first_ada", first_seen, v.first_ada);
                chk("glyph_last_ada", last_seen, v.last_ada);
                if (chain) begin
                    chr_code  = nv.code;
                    chr_col   = nv.col;
                    chr_row   = nv.row;
                    chr_valid = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int good;
        int dones;
        int ready_hi;
        int nw;
        tbl[0] = '{7'h41, 5'd2,  4'd1,  16'h1010, 16'h1F17};
        tbl[1] = '{7'h7F, 5'd31, 4'd15, 16'hF0F8, 16'hFFFF};
        tbl[2] = '{7'h00, 5'd0,  4'd0,  16'h0000, 16'h0F07};
        tbl[3] = '{7'h20, 5'd17, 4'd9,  16'h9088, 16'h9F8F};

        reseta    = 1'b1;
        chr_valid = 1'b0;
        chr_code  = '0;
        chr_col   = '0;
        chr_row   = '0;
        clr_req   = 1'b0;
        clr_val   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cea", cea, 0);
        chk("rst_ada", ada, 0);
        chk("rst_din", din, 0);
        chk("rst_font_addr", font_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reseta = 1'b0;
        #1;
        chk("rst_ready", chr_ready, 1);

        // Back-to-back glyphs straight from the vector table.
        for (int i = 0; i < 4; i++) begin
            run_glyph(tbl[i], i < 3, tbl[(i + 1) % 4], i > 0);
        end

        // Clear and character requested together: clear wins, character follows.
        @(negedge clk);
        chr_code  = tbl[0].code;
        chr_col   = tbl[0].col;
        chr_row   = tbl[0].row;
        chr_valid = 1'b1;
        clr_req   = 1'b1;
        clr_val   = 1'b0;
        #1;
        chk("arb_ready_low", chr_ready, 0);
        @(posedge clk);
        good     = 0;
        dones    = 0;
        ready_hi = 0;
        for (int k = 1; k <= 65537; k++) begin
            @(negedge clk);
            if (k == 1) clr_req = 1'b0;
            if (k <= 65536) begin
                if (cea && ada == 16'(k - 1) && din == 1'b0 && busy) good++;
                if (done) dones++;
                if (chr_ready) ready_hi++;
            end else begin
                chk("clear_writes", good, 65536);
                chk("clear_done_early", dones, 0);
                chk("clear_ready_low", ready_hi, 0);
                chk("clear_done", done, 1);
                chk("clear_busy_end", busy, 0);
                chk("clear_cea_end", cea, 0);
                chk("clear_ada_wrap", ada, 0);
            end
        end
        run_glyph(tbl[0], 1'b0, tbl[0], 1'b1);

        // Reset at the 50th write of a glyph, then render again from line 0.
        @(negedge clk);
        chr_code  = tbl[1].code;
        chr_col   = tbl[1].col;
        chr_row   = tbl[1].row;
        chr_valid = 1'b1;
        #1;
        chk("rstmid_ready", chr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chr_valid = 1'b0;
        nw = 0;
        for (int g = 0; g < 400 && nw < 50; g++) begin
            if (cea) nw++;
            if (nw < 50) @(negedge clk);
        end
        chk("rstmid_writes", nw, 50);
        reseta = 1'b1;
        #1;
        chk("rstmid_cea", cea, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        @(negedge clk);
        reseta = 1'b0;
        run_glyph(tbl[2], 1'b0, tbl[2], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
